// File: rtl/aemb2_pkg.sv
// aemb2_pkg: shared types and defaults for the AEMB2 instruction fetch front end.
package aemb2_pkg;

    localparam int          AEMB_IWB_DEF = 32;
    localparam logic [29:0] RST_PC_DEF   = 30'h0;

    typedef struct packed {
        logic [31:2] pc;
        logic [31:0] ins;
    } fetch_ent_t;

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} fsm_t;

    function automatic int clog2(input int n);
        int r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

endpackage

// File: rtl/aemb2_sync_fifo.sv
// aemb2_sync_fifo: flushable synchronous FIFO; the head output holds its last value while empty.
module aemb2_sync_fifo
    import aemb2_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = clog2(DEPTH),
    parameter int W     = 62
) (
    input  logic          gclk,
    input  logic          grst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [AW:0]   lvl
);

    logic [W-1:0]  mem [DEPTH];
    logic [W-1:0]  hold;
    logic [AW-1:0] wp, rp;
    logic          ne;

    assign ne   = (lvl != '0);
    assign dout = ne ? mem[rp] : hold;

    always_ff @(posedge gclk or negedge grst) begin
        if (!grst) begin
            wp   <= '0;
            rp   <= '0;
            lvl  <= '0;
            hold <= '0;
        end else begin
            if (ne) hold <= mem[rp];
            if (flush) begin
                wp  <= '0;
                rp  <= '0;
                lvl <= '0;
            end else begin
                if (push) wp <= wp + AW'(1);
                if (pop) rp <= rp + AW'(1);
                lvl <= lvl + (AW+1)'(push) - (AW+1)'(pop);
            end
        end
    end

    // storage carries no reset; only slots below lvl are ever observed
    always_ff @(posedge gclk) begin
        if (push && !flush) mem[wp] <= din;
    end

endmodule

// File: rtl/aemb2_iwb_prefetch.sv
// aemb2_iwb_prefetch: Wishbone instruction prefetcher with back-to-back reads,
// a prefetch FIFO toward decode, and clean discard of in-flight reads on redirect.
module aemb2_iwb_prefetch
    import aemb2_pkg::*;
#(
    parameter int          AEMB_IWB = AEMB_IWB_DEF,
    parameter int          DEPTH    = 4,
    parameter int          AW       = clog2(DEPTH),
    parameter logic [29:0] RST_PC   = RST_PC_DEF
) (
    input  logic                  gclk,
    input  logic                  grst,
    input  logic                  dena,
    input  logic                  hzd_fwd,
    input  logic [1:0]            bra_ex,
    input  logic [29:0]           bpc_ex,
    output logic [AEMB_IWB-3:0]   iwb_adr_o,
    output logic                  iwb_stb_o,
    output logic                  iwb_cyc_o,
    output logic [3:0]            iwb_sel_o,
    output logic                  iwb_wre_o,
    input  logic                  iwb_ack_i,
    input  logic [31:0]           iwb_dat_i,
    output logic                  fet_fb,
    output logic [31:0]           fet_ins,
    output logic [29:0]           rpc_if,
    output logic [AW:0]           fet_lvl
);

    localparam int AB = AEMB_IWB - 2;

    fsm_t          state, state_nx;
    logic [AB-1:0] radr, radr_nx, adr_q, rtgt;
    logic          bra, pop, push, load, room_now, room_nxt;
    fetch_ent_t    din_ent, head;

    assign bra      = bra_ex[1];
    assign pop      = dena & ~hzd_fwd & fet_fb & ~bra;
    assign push     = (state == REQ) & iwb_ack_i & ~bra;
    assign room_now = (int'(fet_lvl) - int'(pop)) < DEPTH;
    assign room_nxt = (int'(fet_lvl) + 1 - int'(pop)) < DEPTH;
    assign fet_fb   = (fet_lvl != '0);
    assign din_ent  = '{pc: 30'(adr_q), ins: iwb_dat_i};
    assign fet_ins  = head.ins;
    assign rpc_if   = head.pc;

    always_ff @(posedge gclk or negedge grst) begin
        if (!grst) state <= IDLE;
        else state <= state_nx;
    end

    // a redirect during an outstanding read waits for that ack in DISCARD before re-issuing
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (bra || room_now) ? REQ : IDLE;
            REQ:     state_nx = iwb_ack_i ? ((!bra && room_nxt) ? REQ : IDLE) : (bra ? DISCARD : REQ);
            DISCARD: state_nx = iwb_ack_i ? IDLE : DISCARD;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        iwb_stb_o = (state != IDLE);
        iwb_cyc_o = (state != IDLE);
        iwb_sel_o = (state != IDLE) ? 4'hF : 4'h0;
        iwb_wre_o = 1'b0;
        iwb_adr_o = adr_q;
    end

    assign radr_nx = bra ? AB'(bpc_ex) :
                     push ? radr + AB'(1) :
                     (state == DISCARD && iwb_ack_i) ? rtgt : radr;
    assign load    = (state_nx == REQ) && (state != REQ || iwb_ack_i);

    always_ff @(posedge gclk or negedge grst) begin
        if (!grst) begin
            radr  <= AB'(RST_PC);
            adr_q <= AB'(RST_PC);
            rtgt  <= AB'(RST_PC);
        end else begin
            radr <= radr_nx;
            if (load) adr_q <= radr_nx;
            if (bra) rtgt <= AB'(bpc_ex);
        end
    end

    aemb2_sync_fifo #(
        .DEPTH(DEPTH),
        .AW   (AW),
        .W    ($bits(fetch_ent_t))
    ) u_fifo (
        .gclk (gclk),
        .grst (grst),
        .flush(bra),
        .push (push),
        .pop  (pop),
        .din  (din_ent),
        .dout (head),
        .lvl  (fet_lvl)
    );

endmodule

// File: tb/tb_aemb2_iwb_prefetch.sv
// tb_aemb2_iwb_prefetch: directed stimulus with a scoreboard of expected fetched PCs.
module tb_aemb2_iwb_prefetch;
    import aemb2_pkg::*;

    logic        gclk = 0, grst = 0, dena = 0, hzd_fwd = 0;
    logic [1:0]  bra_ex = 0;
    logic [29:0] bpc_ex = 0;
    logic [29:0] iwb_adr_o;
    logic        iwb_stb_o, iwb_cyc_o, iwb_wre_o, iwb_ack_i;
    logic [3:0]  iwb_sel_o;
    logic [31:0] iwb_dat_i;
    logic        fet_fb;
    logic [31:0] fet_ins;
    logic [29:0] rpc_if;
    logic [2:0]  fet_lvl;
    logic        ack_en = 0, ack_force = 0;
    int          n_chk = 0, n_pass = 0, pops = 0, acks = 0;
    logic [29:0] exp_q[$];
    logic [29:0] a;

    function automatic logic [31:0] mem_of(input logic [29:0] x);
        return {x, 2'b11} ^ 32'h5A5A_1234;
    endfunction

    always #5 gclk = ~gclk;

    assign iwb_ack_i = (iwb_stb_o & ack_en) | ack_force;
    assign iwb_dat_i = mem_of(iwb_adr_o);

    aemb2_iwb_prefetch dut (
        .gclk(gclk), .grst(grst), .dena(dena), .hzd_fwd(hzd_fwd),
        .bra_ex(bra_ex), .bpc_ex(bpc_ex),
        .iwb_adr_o(iwb_adr_o), .iwb_stb_o(iwb_stb_o), .iwb_cyc_o(iwb_cyc_o),
        .iwb_sel_o(iwb_sel_o), .iwb_wre_o(iwb_wre_o), .iwb_ack_i(iwb_ack_i),
        .iwb_dat_i(iwb_dat_i), .fet_fb(fet_fb), .fet_ins(fet_ins),
        .rpc_if(rpc_if), .fet_lvl(fet_lvl)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    // monitor: every accepted pop is compared against the scoreboard head
    always @(negedge gclk) begin
        if (grst) begin
            if (iwb_stb_o && iwb_ack_i) acks++;
            if (fet_fb && dena && !hzd_fwd && !bra_ex[1]) begin
                pops++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_pop", 32'(rpc_if), 32'hFFFF_FFFF);
                end else begin
                    a = exp_q.pop_front();
                    chk("pop_pc", 32'(rpc_if), 32'(a));
                    chk("pop_ins", fet_ins, mem_of(a));
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge gclk);
        #1;
    endtask

    task automatic do_reset();
        grst = 0; dena = 0; hzd_fwd = 0; bra_ex = 0; ack_en = 0; ack_force = 0;
        exp_q.delete();
        tick(2);
        pops = 0; acks = 0;
        grst = 1;
    endtask

    task automatic redirect(input logic [29:0] t);
        bra_ex = 2'b10; bpc_ex = t;
        exp_q.delete();
        tick(1);
        bra_ex = 2'b00;
    endtask

    task automatic expect_seq(input logic [29:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 30'(i));
    endtask

    task automatic drain(input string name, input int n);
        int p0 = pops;
        int k = 0;
        dena = 1;
        while (pops - p0 < n && k < 60) begin
            tick(1);
            k++;
        end
        dena = 0;
        chk(name, 32'(pops - p0 >= n), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #2;
        chk("rst_stb", 32'(iwb_stb_o), 0);
        chk("rst_cyc", 32'(iwb_cyc_o), 0);
        chk("rst_sel", 32'(iwb_sel_o), 0);
        chk("rst_wre", 32'(iwb_wre_o), 0);
        chk("rst_fb", 32'(fet_fb), 0);
        chk("rst_lvl", 32'(fet_lvl), 0);
        chk("rst_ins", fet_ins, 0);
        chk("rst_pc", 32'(rpc_if), 0);

        // streaming with zero-wait acks
        do_reset();
        ack_en = 1; dena = 1;
        expect_seq(30'h0, 20);
        for (int k = 0; k < 8; k++) begin
            tick(1);
            chk("seq_stb", 32'(iwb_stb_o), 1);
            chk("seq_adr", 32'(iwb_adr_o), 32'(k));
        end
        chk("seq_pops", 32'(pops), 6);

        // fill to full, hazard blocks pop, single pop frees one slot
        do_reset();
        ack_en = 1;
        tick(5);
        chk("full_stb", 32'(iwb_stb_o), 0);
        chk("full_lvl", 32'(fet_lvl), 4);
        tick(2);
        chk("full_acks", 32'(acks), 4);
        ack_force = 1;
        tick(1);
        ack_force = 0;
        chk("late_ack_lvl", 32'(fet_lvl), 4);
        hzd_fwd = 1; dena = 1;
        tick(1);
        hzd_fwd = 0; dena = 0;
        chk("hzd_lvl", 32'(fet_lvl), 4);
        chk("hzd_stb", 32'(iwb_stb_o), 0);
        exp_q.push_back(30'h0);
        dena = 1;
        tick(1);
        dena = 0;
        chk("pop1_stb", 32'(iwb_stb_o), 1);
        chk("pop1_adr", 32'(iwb_adr_o), 4);
        chk("pop1_lvl", 32'(fet_lvl), 3);
        tick(1);
        chk("refill_stb", 32'(iwb_stb_o), 0);
        chk("refill_lvl", 32'(fet_lvl), 4);
        chk("refill_acks", 32'(acks), 5);
        tick(2);
        chk("refill_idle", 32'(iwb_stb_o), 0);
        expect_seq(30'h1, 10);
        drain("full_drain", 8);

        // redirect with the ack delayed: old address held, its data dropped
        do_reset();
        tick(1);
        chk("d_stb", 32'(iwb_stb_o), 1);
        redirect(30'h100);
        chk("d_hold_stb", 32'(iwb_stb_o), 1);
        chk("d_hold_adr", 32'(iwb_adr_o), 0);
        tick(1);
        chk("d_hold_adr2", 32'(iwb_adr_o), 0);
        ack_en = 1;
        tick(1);
        chk("d_gap_stb", 32'(iwb_stb_o), 0);
        chk("d_drop_fb", 32'(fet_fb), 0);
        chk("d_drop_lvl", 32'(fet_lvl), 0);
        tick(1);
        chk("d_new_stb", 32'(iwb_stb_o), 1);
        chk("d_new_adr", 32'(iwb_adr_o), 32'h100);
        tick(1);
        chk("d_first_fb", 32'(fet_fb), 1);
        chk("d_first_pc", 32'(rpc_if), 32'h100);
        chk("d_first_ins", fet_ins, mem_of(30'h100));
        expect_seq(30'h100, 6);
        drain("d_drain", 4);

        // redirect coincident with ack, then retargeting during discard
        do_reset();
        ack_en = 1;
        tick(1);
        chk("c_adr", 32'(iwb_adr_o), 0);
        redirect(30'h80);
        ack_en = 0;
        chk("c_stb", 32'(iwb_stb_o), 0);
        chk("c_fb", 32'(fet_fb), 0);
        tick(1);
        chk("c_req_adr", 32'(iwb_adr_o), 32'h80);
        redirect(30'h180);
        redirect(30'h200);
        chk("c_hold_stb", 32'(iwb_stb_o), 1);
        chk("c_hold_adr", 32'(iwb_adr_o), 32'h80);
        ack_en = 1;
        tick(1);
        chk("c_gap_stb", 32'(iwb_stb_o), 0);
        chk("c_gap_fb", 32'(fet_fb), 0);
        tick(1);
        chk("c_new_stb", 32'(iwb_stb_o), 1);
        chk("c_new_adr", 32'(iwb_adr_o), 32'h200);
        expect_seq(30'h200, 6);
        drain("c_drain", 4);

        // word address wraps to zero without a stall
        do_reset();
        tick(1);
        ack_en = 1;
        redirect(30'h3FFF_FFFF);
        tick(1);
        chk("w_adr", 32'(iwb_adr_o), 32'h3FFF_FFFF);
        tick(1);
        chk("w_wrap_stb", 32'(iwb_stb_o), 1);
        chk("w_wrap_adr", 32'(iwb_adr_o), 0);
        exp_q.push_back(30'h3FFF_FFFF);
        expect_seq(30'h0, 4);
        drain("w_drain", 5);

        // asynchronous reset in the middle of a read
        do_reset();
        ack_en = 1;
        tick(3);
        chk("a_pre_lvl", 32'(fet_lvl), 2);
        chk("a_pre_stb", 32'(iwb_stb_o), 1);
        ack_en = 0;
        #2;
        grst = 0; ack_force = 1;
        #1;
        chk("a_stb", 32'(iwb_stb_o), 0);
        chk("a_cyc", 32'(iwb_cyc_o), 0);
        chk("a_sel", 32'(iwb_sel_o), 0);
        chk("a_fb", 32'(fet_fb), 0);
        chk("a_lvl", 32'(fet_lvl), 0);
        chk("a_ins", fet_ins, 0);
        chk("a_pc", 32'(rpc_if), 0);
        tick(1);
        ack_force = 0;
        exp_q.delete();
        pops = 0;
        grst = 1;
        chk("a_rel_fb", 32'(fet_fb), 0);
        ack_en = 1;
        tick(1);
        chk("a_restart_stb", 32'(iwb_stb_o), 1);
        chk("a_restart_adr", 32'(iwb_adr_o), 0);
        expect_seq(30'h0, 8);
        drain("a_drain", 6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/aemb2_iwb_prefetch.md
Name: aemb2_iwb_prefetch

Overview:
Parametrised instruction-fetch front end for the AEMB2 core. It fetches sequential instructions over a classic Wishbone read port into a DEPTH-entry prefetch FIFO. It supplies instruction and PC to the decode stage, and redirects/flushes on execute-stage branches. Unlike the single-slot fetch block, bus transactions are decoupled from the pipeline, back-to-back reads are issued, and in-flight reads are discarded cleanly on redirect.

Parameters:
AEMB_IWB, 32, instruction bus address width; addresses carried as [AEMB_IWB-1:2].
DEPTH, 4, prefetch FIFO entries; power of 2, 2..16.
AW, 2, log2(DEPTH); must equal clog2(DEPTH).
RST_PC, 30'h0, word address fetched first after reset.

Ports:
gclk  in  1  core clock, rising edge.
grst  in  1  reset, asynchronous assert, active-low (0 = reset), synchronous deassert done externally.
dena  in  1  pipeline advance enable; pop qualifier.
hzd_fwd  in  1  decode hazard; blocks pop.
bra_ex  in  2  [1] = redirect taken this cycle; [0] unused, reserved.
bpc_ex  in  30  redirect target word address [31:2].
iwb_adr_o  out  AEMB_IWB-2  Wishbone word address.
iwb_stb_o  out  1  Wishbone strobe.
iwb_cyc_o  out  1  Wishbone cycle; always equal to iwb_stb_o.
iwb_sel_o  out  4  byte selects.
iwb_wre_o  out  1  write enable; constant 0.
iwb_ack_i  in  1  Wishbone acknowledge.
iwb_dat_i  in  32  Wishbone read data.
fet_fb  out  1  FIFO head valid (non-empty).
fet_ins  out  32  head instruction.
rpc_if  out  30  head PC [31:2].
fet_lvl  out  AW+1  FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (grst=0, asynchronous) clears state:
  - stb/cyc=0, sel=4'h0, fet_fb=0, fet_lvl=0, FIFO pointers=0, discard flag=0.
  - rADR=RST_PC; fet_ins and rpc_if=0.
- pop = dena & !hzd_fwd & fet_fb & !bra_ex[1]. Head advances on the next clock edge.
- Issue rule: when stb=0, discard=0, and (fet_lvl - pop) < DEPTH, drive stb=1 next cycle with adr=rADR and sel=4'hF.
- Request handling:
  - stb, once raised, is held with a stable address until ack. There is at most one outstanding read.
  - On ack with discard=0 and no redirect: push {rADR, iwb_dat_i} and set rADR<=rADR+1.
  - stb stays 1 (back-to-back, new address) if (fet_lvl + 1 - pop) < DEPTH; otherwise it drops to 0.
- Address increment wraps modulo 2^(AEMB_IWB-2). No carry or error.
- Redirect (bra_ex[1]=1) takes priority over pop and push in the same cycle:
  - FIFO flushed (lvl=0, fet_fb=0 next cycle); rADR<=bpc_ex.
  - If stb=1 and ack=0: set discard=1 and latch bpc_ex in rTGT. stb holds at the old address until ack. That ack is dropped, discard clears, and stb drops for 1 cycle, then re-issues at rTGT.
  - If stb=1 and ack=1 in the same cycle: data is dropped and there is no discard. The next request goes to bpc_ex under the issue rule.
  - A redirect while discard=1 overwrites rTGT. The latest target wins.
- Full: no issue while lvl=DEPTH; simultaneous pop frees the slot in the same cycle. Empty: fet_fb=0; fet_ins/rpc_if hold their last value.
- Push and pop in the same cycle: lvl unchanged; a push into an empty FIFO is visible on fet_fb the next cycle (1-cycle ack-to-valid latency).
- Throughput: 1 instruction/cycle sustained with zero-wait-state ack.
- First request after reset release: stb=1 on the first clock edge after release, adr=RST_PC.

Decomposition:
- Shared package aemb2_pkg holds:
  - the AEMB_IWB default;
  - the RST_PC default;
  - the FIFO entry struct {pc[31:2], ins[31:0]};
  - a clog2 constant function.
- One sub-module, aemb2_sync_fifo (DEPTH, width 62, flush input, lvl output), is natural. The bus/redirect FSM (IDLE, REQ, DISCARD) stays in the top.

Test Plan:
- Reset then zero-wait ack, dena=1: stb=1 on the first edge at adr 0. Addresses 0,1,2,3... issue on consecutive cycles, and rpc_if/fet_ins match the memory model in order.
- dena=0, DEPTH=4: exactly 4 acks accepted, then stb=0 and fet_lvl=4. Raising dena for 1 cycle pops 1 entry, and exactly one new request (adr 4) follows.
- Redirect with bpc_ex=30'h100 while stb=1 and ack delayed 3 cycles: the old address is held, the delayed ack data is not pushed, the next stb has adr 30'h100, and the first fet_ins is mem[0x100].
- Redirect coincident with ack, then a second redirect to 30'h200 during discard: no stale push occurs, and fetch resumes at 30'h200 only.
- rADR = 30'h3FFFFFFF sequential fetch: the next address is 30'h0, with no stall.
- grst asserted mid-transaction (stb=1): all outputs are at reset values immediately, without waiting for a clock edge. After release, fetch restarts at RST_PC and late acks are ignored while stb=0.
